// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator slope controller and datapath.
package fg_pkg;

  localparam int PHASE_W = 2;

  // Phase encodings. The datapath uses the same values to pick its adder and clamp.
  typedef enum logic [PHASE_W-1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } phase_t;

endpackage

// File: rtl/fg_prescaler.sv
// Sample-rate divider: one clk_en_o pulse every prescaler_i+1 clocks while enabled.
module fg_prescaler #(
  parameter int PRESCALER_BITWIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          en_i,
  input  logic [PRESCALER_BITWIDTH-1:0] prescaler_i,
  output logic                          clk_en_o
);

  logic [PRESCALER_BITWIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                          clk_en_q, clk_en_d;

  // Count up to prescaler_i, then wrap and raise the enable for one clock.
  // A reload value below the current count lets the counter run to its
  // natural wrap; that is harmless and avoids an extra magnitude compare.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    clk_en_d  = 1'b0;
    if (!en_i) begin
      pre_cnt_d = '0;
    end else if (pre_cnt_q == prescaler_i) begin
      pre_cnt_d = '0;
      clk_en_d  = 1'b1;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  // Counter and enable registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pre_cnt_q <= '0;
      clk_en_q  <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      clk_en_q  <= clk_en_d;
    end
  end

  // Registered enable straight to the port.
  always_comb begin
    clk_en_o = clk_en_q;
  end

endmodule

// File: rtl/fg_waveform_sequencer.sv
// Slope sequencer: period counter, per-period shadow config and phase FSM.
//
//   state | meaning
//   IDLE  | waveform finished falling, wait for next period start
//   RISE  | ramping up towards amplitude
//   ON    | holding at amplitude until the ON-time compare
//   FALL  | ramping down towards zero
module fg_waveform_sequencer
  import fg_pkg::*;
#(
  parameter int COUNTER_BITWIDTH   = 32,
  parameter int WAVEFORM_BITWIDTH  = 16,
  parameter int PRESCALER_BITWIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          en_i,
  input  logic [PRESCALER_BITWIDTH-1:0] prescaler_i,
  input  logic [COUNTER_BITWIDTH-1:0]   counter_i,
  input  logic [COUNTER_BITWIDTH-1:0]   ON_counter_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  amplitude_i,
  input  logic [WAVEFORM_BITWIDTH:0]    val_i,
  output logic                          clk_en_o,
  output logic [COUNTER_BITWIDTH-1:0]   CR_o,
  output logic [1:0]                    phase_o,
  output logic                          period_start_o
);

  localparam int VW = WAVEFORM_BITWIDTH + 1;

  logic                        clk_en;
  logic [COUNTER_BITWIDTH-1:0] cr_q, cr_d;
  logic [COUNTER_BITWIDTH-1:0] per_q, per_d;
  logic [COUNTER_BITWIDTH-1:0] on_q, on_d;
  logic [VW-1:0]               amp_q, amp_d;
  phase_t                      phase_q, phase_d;
  logic                        cr_zero, cr_at_on, val_ge_amp, val_le_zero;

  fg_prescaler #(
    .PRESCALER_BITWIDTH(PRESCALER_BITWIDTH)
  ) u_prescaler (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .prescaler_i(prescaler_i),
    .clk_en_o   (clk_en)
  );

  // Compares shared by the counter and the phase FSM.
  always_comb begin
    cr_zero     = (cr_q == '0);
    cr_at_on    = (cr_q == on_q);
    val_ge_amp  = ($signed(val_i) >= $signed(amp_q));
    val_le_zero = val_i[VW-1] | (val_i == '0);
  end

  // Period counter and shadow capture; the wrap compare uses the shadow
  // still in force, so a new period length only applies from the next period.
  always_comb begin
    cr_d  = cr_q;
    per_d = per_q;
    on_d  = on_q;
    amp_d = amp_q;
    if (!en_i) begin
      cr_d = '0;
    end else if (clk_en) begin
      cr_d = (cr_q == per_q) ? '0 : cr_q + 1'b1;
      if (cr_zero) begin
        per_d = counter_i;
        on_d  = ON_counter_i;
        amp_d = {1'b0, amplitude_i};
      end
    end
  end

  // Counter and shadow registers; shadows survive an en_i clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cr_q  <= '0;
      per_q <= '0;
      on_q  <= '0;
      amp_q <= '0;
    end else begin
      cr_q  <= cr_d;
      per_q <= per_d;
      on_q  <= on_d;
      amp_q <= amp_d;
    end
  end

  // Phase state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      phase_q <= IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase next-state: period start restarts the rise from any phase; in RISE
  // the ON-time compare wins over reaching amplitude.
  always_comb begin
    phase_d = phase_q;
    if (!en_i) begin
      phase_d = IDLE;
    end else if (clk_en) begin
      if (cr_zero) begin
        phase_d = RISE;
      end else begin
        unique case (phase_q)
          RISE: begin
            if (cr_at_on)        phase_d = FALL;
            else if (val_ge_amp) phase_d = ON;
          end
          ON:   if (cr_at_on)    phase_d = FALL;
          FALL: if (val_le_zero) phase_d = IDLE;
          IDLE: phase_d = IDLE;
          default: phase_d = IDLE;
        endcase
      end
    end
  end

  // Outputs: all registered except period_start_o, decoded from registers.
  always_comb begin
    clk_en_o       = clk_en;
    CR_o           = cr_q;
    phase_o        = phase_q;
    period_start_o = clk_en & cr_zero;
  end

endmodule

// File: tb/tb_fg_waveform_sequencer.sv
// Bench for fg_waveform_sequencer: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the sequencer.
module tb_fg_waveform_sequencer;

  localparam int CW = 32;
  localparam int WW = 16;
  localparam int PW = 16;
  localparam int VW = WW + 1;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          en_i;
  logic [PW-1:0] prescaler_i;
  logic [CW-1:0] counter_i;
  logic [CW-1:0] ON_counter_i;
  logic [WW-1:0] amplitude_i;
  logic [VW-1:0] val_i;
  logic          clk_en_o;
  logic [CW-1:0] CR_o;
  logic [1:0]    phase_o;
  logic          period_start_o;

  fg_waveform_sequencer #(
    .COUNTER_BITWIDTH  (CW),
    .WAVEFORM_BITWIDTH (WW),
    .PRESCALER_BITWIDTH(PW)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .en_i          (en_i),
    .prescaler_i   (prescaler_i),
    .counter_i     (counter_i),
    .ON_counter_i  (ON_counter_i),
    .amplitude_i   (amplitude_i),
    .val_i         (val_i),
    .clk_en_o      (clk_en_o),
    .CR_o          (CR_o),
    .phase_o       (phase_o),
    .period_start_o(period_start_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model state: phases as 0=IDLE 1=RISE 2=ON 3=FALL.
  int m_pre, m_tk, m_cr, m_ph, m_per, m_on, m_amp;
  int v;
  int fall_seen, on_seen, idle_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_tk = 0; m_cr = 0; m_ph = 0;
    m_per = 0; m_on = 0; m_amp = 0;
  endtask

  // One clock edge of the sequencer described from its rules.
  task automatic model_step();
    int nxt_ph;
    if (!en_i) begin
      m_pre = 0; m_tk = 0; m_cr = 0; m_ph = 0;
      return;
    end
    if (m_tk != 0) begin
      nxt_ph = m_ph;
      if (m_cr == 0)                      nxt_ph = 1;
      else if (m_ph == 1 && m_cr == m_on) nxt_ph = 3;
      else if (m_ph == 1 && v >= m_amp)   nxt_ph = 2;
      else if (m_ph == 2 && m_cr == m_on) nxt_ph = 3;
      else if (m_ph == 3 && v <= 0)       nxt_ph = 0;
      if (m_cr == 0) begin
        m_cr  = (m_per == 0) ? 0 : 1;
        m_per = int'(counter_i);
        m_on  = int'(ON_counter_i);
        m_amp = int'(amplitude_i);
      end else begin
        m_cr = (m_cr == m_per) ? 0 : m_cr + 1;
      end
      m_ph = nxt_ph;
    end
    if (m_pre == int'(prescaler_i)) begin
      m_pre = 0; m_tk = 1;
    end else begin
      m_pre = (m_pre + 1) % 65536; m_tk = 0;
    end
  endtask

  task automatic check_outputs();
    check("clk_en", clk_en_o, m_tk);
    check("cr", CR_o, m_cr);
    check("phase", phase_o, m_ph);
    check("pstart", period_start_o, (m_tk != 0 && m_cr == 0));
    if (m_ph == 3) fall_seen++;
    if (m_ph == 2) on_seen++;
    if (m_ph == 0 && en_i) idle_seen++;
  endtask

  task automatic set_val(input int nv);
    v = nv;
    val_i = v[VW-1:0];
  endtask

  // Advance one clock: model follows the edge, outputs checked mid-cycle.
  task automatic cycle();
    @(posedge clk_i);
    if (rstn_i) model_step();
    @(negedge clk_i);
    check_outputs();
  endtask

  initial begin
    fall_seen = 0; on_seen = 0; idle_seen = 0;
    rstn_i = 1'b0; en_i = 1'b0;
    prescaler_i = '0; counter_i = '0; ON_counter_i = '0; amplitude_i = '0;
    set_val(0);
    model_reset();
    #1;
    check("rst_cr", CR_o, 0);
    check("rst_phase", phase_o, 0);
    check("rst_clk_en", clk_en_o, 0);
    check("rst_pstart", period_start_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Divide by 4, fixed val below amplitude.
    prescaler_i = 16'd3; counter_i = 9; ON_counter_i = 5; amplitude_i = 16'd1000;
    set_val(100);
    en_i = 1'b1;
    repeat (30) cycle();

    // Full rate, hold val: RISE then FALL at CR=5, never reaching zero.
    en_i = 1'b0; prescaler_i = 16'd0;
    cycle();
    en_i = 1'b1;
    repeat (30) cycle();

    // Ramp val up while rising, drop to zero once falling.
    repeat (60) begin
      if (m_ph == 3 && m_cr >= 7) set_val(0);
      else if (m_ph == 1)         set_val(v + 300);
      else if (m_cr == 0)         set_val(0);
      cycle();
    end

    // Shrink the period mid-period, and ON time 0.
    while (m_cr != 3) cycle();
    counter_i = 4; ON_counter_i = 0;
    set_val(100);
    repeat (40) cycle();

    // Asynchronous reset between edges while falling.
    counter_i = 9; ON_counter_i = 5; set_val(100);
    for (int i = 0; i < 40 && m_ph != 3; i++) cycle();
    check("reach_fall", m_ph, 3);
    #2;
    rstn_i = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk_i);
    cycle();
    rstn_i = 1'b1;
    repeat (15) cycle();
    en_i = 1'b0;
    cycle();
    en_i = 1'b1;
    repeat (5) cycle();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        counter_i    = $urandom_range(0, 12);
        ON_counter_i = $urandom_range(0, 13);
        amplitude_i  = 16'($urandom_range(0, 1500));
      end
      if ($urandom_range(0, 19) == 0) set_val(int'($urandom_range(0, 4000)) - 2000);
      else begin
        set_val(v + int'($urandom_range(0, 600)) - 300);
        if (v > 2000) set_val(2000);
        if (v < -2000) set_val(-2000);
      end
      en_i = 1'b1;
      if ($urandom_range(0, 59) == 0) begin
        en_i = 1'b0;
        prescaler_i = 16'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rstn_i = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk_i);
        cycle();
        rstn_i = 1'b1;
      end
      cycle();
    end

    check("cov_fall", (fall_seen > 0), 1);
    check("cov_on", (on_seen > 0), 1);
    check("cov_idle", (idle_seen > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
